// File: rtl/cfg_initiator.sv
// cfg_initiator: queues register-access commands in a small FIFO and executes
// them one at a time against a register block, returning one response each.
// Writes can optionally be verified by reading the register back. The compare
// uses only the bits implemented at that address.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/verify/addr/wdata     command payload
//   cfg_we/waddr/wdata              write strobe and payload to the register block
//   cfg_raddr/cfg_rdata             read address, combinational read data
//   rsp_valid/rsp_ready             response handshake
//   rsp_addr/rsp_rdata/rsp_err      response payload
//   busy                            command in flight or queued
//   err_count                       saturating count of error responses
module cfg_initiator #(
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_verify,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cfg_we,
  output logic [3:0]  cfg_waddr,
  output logic [31:0] cfg_wdata,
  output logic [3:0]  cfg_raddr,
  input  logic [31:0] cfg_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_addr,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = $clog2(CMD_DEPTH + 1);

  typedef struct packed {
    logic              write;
    logic              verify;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  cmd_t             head;
  cmd_t             work;
  state_t           state;
  state_t           state_nxt;
  logic             push;
  logic             pop;
  logic             cap_wr;
  logic             cap_rd;
  logic             rsp_hs;
  logic [DATA_W-1:0] mask;
  logic             unmapped;
  logic             verify_err;

  assign push      = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign head      = fifo_mem[rd_ptr];
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Register-block outputs come straight from the working command.
  assign cfg_waddr = work.addr;
  assign cfg_wdata = work.wdata;
  assign cfg_raddr = work.addr;

  // Implemented width per address; anything above 6 is unmapped.
  always_comb begin
    mask     = '0;
    unmapped = 1'b0;
    case (work.addr)
      4'd0, 4'd4, 4'd5: mask = 32'hFFFF_FFFF;
      4'd1, 4'd2, 4'd6: mask = 32'h0000_FFFF;
      4'd3:             mask = 32'h0000_00FF;
      default:          unmapped = 1'b1;
    endcase
  end

  assign verify_err = work.write && work.verify &&
                      (unmapped || ((cfg_rdata & mask) != (work.wdata & mask)));

  // Next-state and capture controls.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_wr    = 1'b0;
    cap_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = head.write ? WR : RD;
        end
      end
      WR: begin
        if (work.verify) begin
          state_nxt = RD;
        end else begin
          state_nxt = RSP;
          cap_wr    = 1'b1;
        end
      end
      RD: begin
        state_nxt = RSP;
        cap_rd    = 1'b1;
      end
      RSP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO payload storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_verify, cmd_addr, cmd_wdata};
  end

  // State, pointers, working command and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      work      <= '0;
      cfg_we    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        work   <= head;
      end
      cfg_we    <= (state_nxt == WR);
      cmd_ready <= (count_nxt != CNT_W'(CMD_DEPTH));
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
      rsp_valid <= (state_nxt == RSP);
      if (cap_wr) begin
        rsp_addr  <= work.addr;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      if (cap_rd) begin
        rsp_addr  <= work.addr;
        rsp_rdata <= cfg_rdata;
        rsp_err   <= verify_err;
      end
      if (rsp_hs && rsp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cfg_initiator.sv
// Bench for cfg_initiator: directed vector table, hand-written latency,
// backpressure and reset-abort sequences, then random traffic checked by a
// scoreboard that predicts every response from the address map rules.
`timescale 1ns/1ps
module tb_cfg_initiator;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_verify;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cfg_we;
  logic [3:0]  cfg_waddr, cfg_raddr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;

  cfg_initiator #(.CMD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_verify(cmd_verify), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic        verify;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_ec;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   we_cnt = 0;
  int   hs_cnt = 0;
  int   ec = 0;
  bit   mon_en = 1'b0;
  bit   was_rst = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[13];
  logic [31:0] env_regs [16];
  logic [31:0] exp_regs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register block: widths per address, stuck bits at 5 and 2, 7..15 unmapped.
  function automatic logic [31:0] store_val(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'd0, 4'd4: return d;
      4'd5:       return d & 32'h7FFF_FFFF;
      4'd1, 4'd6: return d & 32'h0000_FFFF;
      4'd2:       return (d & 32'h0000_FFFF) | 32'h0000_0008;
      4'd3:       return d & 32'h0000_00FF;
      default:    return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cfg_we) begin
      we_cnt++;
      if (cfg_waddr <= 4'd6) env_regs[cfg_waddr] = store_val(cfg_waddr, cfg_wdata);
    end
  end

  always @* cfg_rdata = (cfg_raddr <= 4'd6) ? env_regs[cfg_raddr] : 32'hDEAD_BEEF;

  // Reference: responses follow command order, so predict at push time.
  function automatic exp_t predict(input logic w, input logic v, input logic [3:0] a,
                                   input logic [31:0] d);
    exp_t        r;
    logic [31:0] m;
    logic [31:0] rd;
    if (a == 4'd0 || a == 4'd4 || a == 4'd5)      m = 32'hFFFF_FFFF;
    else if (a == 4'd1 || a == 4'd2 || a == 4'd6) m = 32'h0000_FFFF;
    else if (a == 4'd3)                           m = 32'h0000_00FF;
    else                                          m = 32'h0;
    if (w && a <= 4'd6) exp_regs[a] = store_val(a, d);
    rd     = (a <= 4'd6) ? exp_regs[a] : 32'hDEAD_BEEF;
    r.addr = a;
    if (w && !v) begin
      r.rdata = 32'h0;
      r.err   = 1'b0;
    end else if (w) begin
      r.rdata = rd;
      r.err   = (a > 4'd6) || ((rd & m) != (d & m));
    end else begin
      r.rdata = rd;
      r.err   = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard monitor: inputs are driven just after posedge, so at negedge
  // they show what the next edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        q.delete();
        ec = 0;
        was_rst = 1'b1;
      end else begin
        if (was_rst) begin
          for (int i = 0; i < 16; i++) exp_regs[i] = env_regs[i];
          was_rst = 1'b0;
        end
        check("mon_busy", busy, (q.size() != 0));
        if (rsp_valid && rsp_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mon_unexpected_rsp: got addr 0x%0h with no command pending", rsp_addr);
          end else begin
            mon_e = q.pop_front();
            check("mon_addr", rsp_addr, mon_e.addr);
            check("mon_rdata", rsp_rdata, mon_e.rdata);
            check("mon_err", rsp_err, mon_e.err);
            if (mon_e.err && ec < 255) ec++;
          end
        end
        if (cmd_valid && cmd_ready) q.push_back(predict(cmd_write, cmd_verify, cmd_addr, cmd_wdata));
      end
    end
  end

  task automatic run_vec(input int i);
    int w0;
    bit got;
    w0 = we_cnt;
    tick();
    cmd_valid  = 1'b1;
    cmd_write  = vecs[i].write;
    cmd_verify = vecs[i].verify;
    cmd_addr   = vecs[i].addr;
    cmd_wdata  = vecs[i].wdata;
    rsp_ready  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    check($sformatf("vec%0d_accept", i), got, 1);
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check($sformatf("vec%0d_rsp_seen", i), got, 1);
    check($sformatf("vec%0d_addr", i), rsp_addr, vecs[i].addr);
    check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
    check($sformatf("vec%0d_err", i), rsp_err, vecs[i].exp_err);
    @(negedge clk);
    check($sformatf("vec%0d_rsp_drop", i), rsp_valid, 0);
    check($sformatf("vec%0d_err_count", i), err_count, vecs[i].exp_ec);
    check($sformatf("vec%0d_we_pulses", i), 32'(we_cnt - w0), vecs[i].write ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int hs0;
    int w0;
    int bad;
    bit done;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_verify = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      env_regs[i] = 32'h0;
      exp_regs[i] = 32'h0;
    end
    env_regs[3] = 32'h11;
    exp_regs[3] = 32'h11;

    //          wr    vfy   addr   wdata          rdata          err   ec
    vecs[0]  = '{1'b1, 1'b0, 4'd4, 32'h0A00_0200, 32'h0000_0000, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'd1, 32'h1234_BEEF, 32'h0000_BEEF, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'd9, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 4'd4, 32'h0000_0000, 32'h0A00_0200, 1'b0, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 4'd3, 32'h0000_0000, 32'h0000_0011, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 1'b1, 4'd3, 32'h0000_00AB, 32'h0000_00AB, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 1'b1, 4'd3, 32'h0000_1234, 32'h0000_0034, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 1'b1, 4'd5, 32'h8000_0001, 32'h0000_0001, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 1'b1, 4'd2, 32'h0000_0000, 32'h0000_0008, 1'b1, 8'd3};
    vecs[9]  = '{1'b1, 1'b1, 4'd2, 32'hFFFF_0008, 32'h0000_0008, 1'b0, 8'd3};
    vecs[10] = '{1'b0, 1'b1, 4'd9, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 8'd3};
    vecs[11] = '{1'b1, 1'b1, 4'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 8'd3};
    vecs[12] = '{1'b1, 1'b1, 4'd6, 32'h5555_AAAA, 32'h0000_AAAA, 1'b0, 8'd3};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cfg_we", cfg_we, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_err_count", err_count, 0);
    check("rst_cfg_waddr", cfg_waddr, 0);
    check("rst_cfg_wdata", cfg_wdata, 0);
    mon_en = 1'b1;

    // Read of addr 3 straight out of reset: response at push edge + 2.
    tick();
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_verify = 1'b0; cmd_addr = 4'd3; cmd_wdata = '0;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("lat_n_rsp_valid", rsp_valid, 0);
    check("lat_n_busy", busy, 1);
    @(negedge clk);
    check("lat_n1_rsp_valid", rsp_valid, 0);
    check("lat_n1_raddr", cfg_raddr, 3);
    check("lat_n1_we", cfg_we, 0);
    @(negedge clk);
    check("lat_n2_rsp_valid", rsp_valid, 1);
    check("lat_n2_rdata", rsp_rdata, 32'h11);
    check("lat_n2_err", rsp_err, 0);
    @(negedge clk);
    check("lat_stall_hold", rsp_valid, 1);
    check("lat_stall_rdata", rsp_rdata, 32'h11);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_rsp_done", rsp_valid, 0);
    check("lat_idle", busy, 0);

    // Directed vector table.
    for (int i = 0; i < 13; i++) run_vec(i);
    check("model_reg4", env_regs[4], 32'h0A00_0200);

    // Backpressure: five reads fill FIFO plus the one stalled in RSP.
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_verify = 1'b0;
    cmd_addr = 4'd0; acc = 0; hs0 = hs_cnt;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      @(negedge clk);
      if (cmd_ready) acc++;
      tick();
      cmd_addr = 4'(acc);
    end
    check("bp_accepted", acc, 5);
    repeat (3) begin
      @(negedge clk);
      check("bp_full_ready", cmd_ready, 0);
      check("bp_stalled_valid", rsp_valid, 1);
    end
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (hs_cnt - hs0) < 5; c++) @(negedge clk);
    check("bp_responses", 32'(hs_cnt - hs0), 5);
    @(negedge clk);
    check("bp_idle", busy, 0);

    // Reset while the write strobe is up.
    w0 = we_cnt;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_verify = 1'b1; cmd_addr = 4'd0;
    cmd_wdata = 32'h0BAD_0BAD;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("abort_we_in_wr", cfg_we, 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("abort_we_low", cfg_we, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_err_count", err_count, 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || cfg_we || busy) bad++;
    end
    check("abort_quiet_cycles", bad, 0);
    check("abort_we_pulses", 32'(we_cnt - w0), 1);

    // Random traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      tick();
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_write  = 1'($urandom_range(0, 1));
      cmd_verify = 1'($urandom_range(0, 1));
      cmd_addr   = 4'($urandom_range(0, 15));
      cmd_wdata  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rsp_ready  = ($urandom_range(0, 3) != 0);
    end
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    @(negedge clk);
    check("rand_drained", done, 1);
    check("rand_err_count", err_count, 32'(ec));
    check("rand_idle", busy, 0);
    check("rand_cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_initiator.md
CFG_INITIATOR -- requirements
Module: cfg_initiator

Interface
REQ-001 SHALL have parameter: CMD_DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have port: cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port: cmd_verify  input  1  write followed by readback compare (ignored for reads).
REQ-008 SHALL have port: cmd_addr  input  4  register address.
REQ-009 SHALL have port: cmd_wdata  input  32  write data.
REQ-010 SHALL have port: cfg_we  output  1  write strobe to register block.
REQ-011 SHALL have port: cfg_waddr  output  4  write address.
REQ-012 SHALL have port: cfg_wdata  output  32  write data.
REQ-013 SHALL have port: cfg_raddr  output  4  read address.
REQ-014 SHALL have port: cfg_rdata  input  32  combinational read data from register block.
REQ-015 SHALL have port: rsp_valid  output  1  response available.
REQ-016 SHALL have port: rsp_ready  input  1  response consumed.
REQ-017 SHALL have port: rsp_addr  output  4  address of completed command.
REQ-018 SHALL have port: rsp_rdata  output  32  read or readback data; 0 for unverified write.
REQ-019 SHALL have port: rsp_err  output  1  verify mismatch or verify to unmapped address.
REQ-020 SHALL have port: busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-021 SHALL have port: err_count  output  8  saturating count of responses delivered with rsp_err=1.

Function
REQ-022 SHALL push {write,verify,addr,wdata} into the FIFO on cmd_valid&&cmd_ready; cmd_ready = (count != CMD_DEPTH); count range 0..CMD_DEPTH, pointers wrap modulo CMD_DEPTH.
REQ-023 SHALL implement FSM states IDLE, WR, RD, RSP.
REQ-024 IDLE: if FIFO non-empty, pop head into working registers at the edge; go to WR if write else RD; otherwise stay.
REQ-025 WR: cfg_we=1 for exactly this one cycle; next state RD if verify else RSP (rsp_rdata=0, rsp_err=0).
REQ-026 RD: cfg_raddr holds working address; cfg_rdata captured into rsp_rdata at end of the cycle; next state RSP.
REQ-027 RSP: rsp_valid=1 with stable rsp_addr/rsp_rdata/rsp_err until rsp_ready; on handshake go to IDLE.
REQ-028 cfg_waddr, cfg_wdata, cfg_raddr SHALL be driven from the working registers at all times; cfg_we SHALL be 1 only in WR.
REQ-029 Verify compare SHALL mask by address width: 0,4,5 -> 32 bits; 1,2,6 -> 16 bits [15:0]; 3 -> 8 bits [7:0]; rsp_err = masked(cfg_rdata) != masked(wdata); addresses 7-15 with verify SHALL set rsp_err=1.
REQ-030 Plain reads SHALL never set rsp_err.
REQ-031 Latency, empty FIFO, command pushed at edge N: popped at edge N+1; write cfg_we high in cycle N+1..N+2; read/readback sampled at edge N+2 (read) or N+3 (verified write); rsp_valid high from edge N+2 (plain write/read) or N+3 (verified write).
REQ-032 FIFO push and FSM pop in same cycle SHALL both occur, count unchanged.
REQ-033 Commands SHALL complete strictly in FIFO order, one outstanding at a time; rsp_ready low SHALL stall the FSM in RSP while FIFO keeps accepting until full.
REQ-034 err_count SHALL increment on rsp_valid&&rsp_ready&&rsp_err, saturating at 255.

Reset
REQ-035 On rst_n=0 at an edge: FIFO emptied, FSM=IDLE, working addr/wdata=0, cfg_we=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_addr=0, err_count=0, cmd_ready=1, busy=0.
REQ-036 Reset mid-operation (any state) SHALL abort the command with no response and no further cfg_we pulse.

Verification
REQ-037 Write addr 4 data 0x0A000200 no verify into register model -> one cfg_we pulse, model holds 0x0A000200, rsp rdata=0 err=0.
REQ-038 Verified write addr 1 data 0x1234BEEF, model keeps 16 bits -> readback 0x0000BEEF, rsp_err=0.
REQ-039 Verified write addr 9 data 0x1 (model returns 0xDEADBEEF) -> rsp_err=1, err_count=1.
REQ-040 Hold rsp_ready=0, push 5 commands with CMD_DEPTH=4 -> cmd_ready drops after 4 queued plus 1 in RSP; release -> 5 in-order responses.
REQ-041 Read addr 3 after reset (model 0x11) -> rsp_rdata=0x00000011 at edge N+2, err=0.
REQ-042 Assert rst_n=0 during WR -> cfg_we low next cycle, rsp_valid never rises, FIFO empty, err_count=0.
